// File: rtl/dma_channel_arbiter.sv
// DMA request arbiter and bus-hold sequencer: samples channel requests, runs the
// HRQ/HLDA handshake with the CPU and holds one winner's DACK until the service ends.
module dma_channel_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic              priorityType,
  input  logic              HLDA,
  input  logic              EOP_N,
  input  logic              transferDone,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic [CH_W-1:0]   activeChannel,
  output logic              serviceDone,
  output logic              serviceAbort
);

  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;

  state_t              state_q, state_d;
  logic                hrq_q, hrq_d;
  logic [NUM_CH-1:0]   dack_q, dack_d;
  logic [CH_W-1:0]     active_q, active_d;
  logic                done_q, done_d;
  logic                abort_q, abort_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;

  logic [NUM_CH-1:0]   pending;
  logic [CH_W-1:0]     winner;
  logic                found;
  int unsigned         start_idx;
  int unsigned         idx;

  assign pending = DREQ & ~maskReg;

  // Winner search: ascending from the rotation pointer (or ch0 when fixed), wrapping modulo NUM_CH
  always_comb begin
    winner    = '0;
    found     = 1'b0;
    idx       = 0;
    start_idx = 0;
    if (priorityType) start_idx = 32'(ptr_q);
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = start_idx + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && ((pending & (NUM_CH'(1) << idx)) != '0)) begin
        found  = 1'b1;
        winner = idx[CH_W-1:0];
      end
    end
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d  = state_q;
    hrq_d    = hrq_q;
    dack_d   = dack_q;
    active_d = active_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    ptr_d    = ptr_q;
    case (state_q)
      IDLE: begin
        if (pending != '0) begin
          state_d = REQ;
          hrq_d   = 1'b1;
        end
      end
      REQ: begin
        if (pending == '0) begin
          state_d = IDLE;
          hrq_d   = 1'b0;
        end else if (HLDA) begin
          state_d  = GRANT;
          dack_d   = NUM_CH'(1) << winner;
          active_d = winner;
        end
      end
      GRANT: begin
        // Loss of HLDA wins over a completion arriving in the same cycle
        if (!HLDA) begin
          state_d = IDLE;
          hrq_d   = 1'b0;
          dack_d  = '0;
          abort_d = 1'b1;
        end else if (transferDone || !EOP_N) begin
          state_d = RELEASE;
          hrq_d   = 1'b0;
          dack_d  = '0;
          done_d  = 1'b1;
          ptr_d   = (active_q == CH_W'(NUM_CH - 1)) ? '0 : active_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!HLDA) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, output and rotation-pointer registers with asynchronous reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      hrq_q    <= 1'b0;
      dack_q   <= '0;
      active_q <= '0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      hrq_q    <= hrq_d;
      dack_q   <= dack_d;
      active_q <= active_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      ptr_q    <= ptr_d;
    end
  end

  assign HRQ           = hrq_q;
  assign DACK          = dack_q;
  assign activeChannel = active_q;
  assign serviceDone   = done_q;
  assign serviceAbort  = abort_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for dma_channel_arbiter: a 4-channel and an 8-channel instance share
// clock, reset and handshake inputs; each has its own request and mask lines.
module tb_dma_channel_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       hlda, eop_n, xfer_done, ptype;
  logic [3:0] dreq4, mask4, dack4;
  logic [1:0] act4;
  logic       hrq4, done4, abort4;
  logic [7:0] dreq8, mask8, dack8;
  logic [2:0] act8;
  logic       hrq8, done8, abort8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dma_channel_arbiter #(.NUM_CH(4)) dut4 (
    .CLK(clk), .RESET(rst), .DREQ(dreq4), .maskReg(mask4), .priorityType(ptype),
    .HLDA(hlda), .EOP_N(eop_n), .transferDone(xfer_done), .HRQ(hrq4), .DACK(dack4),
    .activeChannel(act4), .serviceDone(done4), .serviceAbort(abort4)
  );

  dma_channel_arbiter #(.NUM_CH(8)) dut8 (
    .CLK(clk), .RESET(rst), .DREQ(dreq8), .maskReg(mask8), .priorityType(ptype),
    .HLDA(hlda), .EOP_N(eop_n), .transferDone(xfer_done), .HRQ(hrq8), .DACK(dack8),
    .activeChannel(act8), .serviceDone(done8), .serviceAbort(abort8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // from IDLE with HLDA low: raise requests, then acknowledge one cycle after HRQ
  task automatic grant(input logic [3:0] d4, input logic [7:0] d8);
    dreq4 = d4;
    dreq8 = d8;
    tick();
    hlda = 1'b1;
    tick();
  endtask

  // complete via transferDone, then drop HLDA and requests and return to IDLE
  task automatic finish_done;
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    hlda  = 1'b0;
    dreq4 = '0;
    dreq8 = '0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; hlda = 1'b0; eop_n = 1'b1; xfer_done = 1'b0; ptype = 1'b0;
    dreq4 = '0; mask4 = '0; dreq8 = '0; mask8 = '0;
    do_reset();
    check("rst_hrq", hrq4, 0);
    check("rst_dack", dack4, 0);
    check("rst_act", act4, 0);
    check("rst_done", done4, 0);
    check("rst_abort", abort4, 0);
    check("rst_dack8", dack8, 0);

    // 1: fixed priority, HRQ latency and grant latency
    dreq4 = 4'b1010;
    tick();
    check("t1_hrq_lat", hrq4, 1);
    tick();
    tick();
    check("t1_no_dack_pre_hlda", dack4, 0);
    hlda = 1'b1;
    tick();
    check("t1_dack", dack4, 4'b0010);
    check("t1_act", act4, 1);
    dreq4 = 4'b0001;
    tick();
    check("t1_dack_hold", dack4, 4'b0010);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    check("t1_done", done4, 1);
    check("t1_dack_clr", dack4, 0);
    check("t1_hrq_clr", hrq4, 0);
    tick();
    check("t1_done_pulse", done4, 0);
    check("t1_release_no_hrq", hrq4, 0);
    hlda = 1'b0; dreq4 = '0;
    tick();
    tick();

    // 2: rotating priority, pointer advance and wrap, pointer kept across fixed mode
    do_reset();
    ptype = 1'b1;
    grant(4'b0010, '0);
    check("t2_ch1", dack4, 4'b0010);
    finish_done();
    grant(4'b1111, '0);
    check("t2_rot_ch2", dack4, 4'b0100);
    finish_done();
    grant(4'b1111, '0);
    check("t2_rot_ch3", dack4, 4'b1000);
    finish_done();
    grant(4'b1111, '0);
    check("t2_wrap_ch0", dack4, 4'b0001);
    finish_done();
    ptype = 1'b0;
    grant(4'b1111, '0);
    check("t2_fixed_ch0", dack4, 4'b0001);
    finish_done();
    ptype = 1'b1;
    grant(4'b1111, '0);
    check("t2_ptr_kept", dack4, 4'b0010);
    finish_done();

    // 3: masking (pointer now 2)
    ptype = 1'b0;
    mask4 = 4'b0001;
    grant(4'b0011, '0);
    check("t3_mask_dack", dack4, 4'b0010);
    mask4 = 4'b0011;
    tick();
    check("t3_mask_no_revoke", dack4, 4'b0010);
    finish_done();
    dreq4 = 4'b0011;
    tick();
    tick();
    check("t3_all_masked_hrq", hrq4, 0);
    dreq4 = '0; mask4 = '0;
    tick();

    // 4: abort beats completion; pointer stays at 2
    ptype = 1'b1;
    grant(4'b0100, '0);
    check("t4_ch2", dack4, 4'b0100);
    hlda = 1'b0; xfer_done = 1'b1; dreq4 = '0;
    tick();
    xfer_done = 1'b0;
    check("t4_dack", dack4, 0);
    check("t4_hrq", hrq4, 0);
    check("t4_abort", abort4, 1);
    check("t4_no_done", done4, 0);
    tick();
    check("t4_abort_pulse", abort4, 0);
    grant(4'b1111, '0);
    check("t4_ptr_unchanged", dack4, 4'b0100);
    finish_done();

    // 5: withdrawal before HLDA, then EOP completion (pointer now 3)
    dreq4 = 4'b0001;
    tick();
    check("t5_hrq_up", hrq4, 1);
    dreq4 = '0;
    tick();
    check("t5_withdraw_hrq", hrq4, 0);
    check("t5_withdraw_dack", dack4, 0);
    grant(4'b0001, '0);
    check("t5_ch0", dack4, 4'b0001);
    eop_n = 1'b0;
    tick();
    eop_n = 1'b1;
    check("t5_eop_done", done4, 1);
    check("t5_eop_dack", dack4, 0);
    tick();
    tick();
    check("t5_release_hold", hrq4, 0);
    hlda = 1'b0;
    tick();
    tick();
    check("t5_rereq", hrq4, 1);
    dreq4 = '0;
    tick();

    // 6: asynchronous reset mid-grant (pointer 1 beforehand), then p=0
    grant(4'b0100, '0);
    check("t6_pre_rst", dack4, 4'b0100);
    rst = 1'b1;
    #1;
    check("t6_async_dack", dack4, 0);
    check("t6_async_hrq", hrq4, 0);
    hlda = 1'b0; dreq4 = '0;
    tick();
    rst = 1'b0;
    tick();
    grant(4'b1111, '0);
    check("t6_ptr_zero", dack4, 4'b0001);
    finish_done();

    // 6b: NUM_CH=8 rotating wrap from ch7
    grant('0, 8'h20);
    check("t8_ch5", dack8, 8'h20);
    finish_done();
    grant('0, 8'hFF);
    check("t8_ch6", dack8, 8'h40);
    finish_done();
    grant('0, 8'hFF);
    check("t8_ch7", dack8, 8'h80);
    check("t8_act7", act8, 7);
    finish_done();
    grant('0, 8'hFF);
    check("t8_wrap", dack8, 8'h01);
    finish_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
